// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types, widths and helpers for the TDC hit-encoding chain.
//   tdc_state_e  - event-capture FSM states
//   CNT_W        - width of the saturating status counters
//   TS_FINE_LSB  - bit offset of the fine field in a timestamp (coarse sits above it)
//   clog2()      - ceil(log2(n)), used to size the fine field
//   sat_inc()    - saturating increment for the status counters
package tdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_FIN = 1'b1
  } tdc_state_e;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TS_FINE_LSB = 0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tdc_ts_fifo.sv
// tdc_ts_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst   - clock and synchronous active-high reset
//   push_i     - write request; ignored when full unless a pop frees a slot the same cycle
//   wdata_i    - write data
//   pop_i      - read request; ignored when empty
//   rdata_o    - head entry while non-empty; holds the last popped value while empty
//   empty_o    - no entries
//   full_o     - 2**AW entries
//   count_o    - current occupancy
module tdc_ts_fifo #(
  parameter int unsigned DW = 23,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [DW-1:0] hold_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    // NOTE: assign a default before any condition in always_comb so no latch is inferred.
    rdata_o = hold_q;
    if (!empty_o) rdata_o = mem_q[rd_ptr_q];
  end

  // NOTE: the storage array has no reset; empty/full come from the reset pointers,
  // so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder: captures a thermometer-coded delay-line snapshot and the coarse
// counter on each stop-filter valid, confirms it with the following finish pulse,
// popcount-encodes the fine value in two pipeline stages and queues {coarse, fine}.
//   clk, rst    - clock and synchronous active-high reset
//   taps        - registered delay-line outputs
//   valid       - stop-filter event strobe
//   finish      - stop-filter confirm, expected one cycle after valid
//   ts_data     - timestamp {coarse, fine} at the FIFO head
//   ts_valid    - FIFO non-empty
//   ts_ready    - consumer accepts the head entry
//   ovf_cnt     - events dropped on a full FIFO (saturating)
//   glitch_cnt  - events discarded for protocol errors (saturating)
module tdc_hit_encoder
  import tdc_pkg::*;
#(
  parameter int unsigned NTAPS    = 64,
  parameter int unsigned COARSE_W = 16,
  parameter int unsigned FINE_W   = clog2(NTAPS + 1),
  parameter int unsigned FIFO_AW  = 2,
  parameter bit          TAP_INV  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NTAPS-1:0]           taps,
  input  logic                       valid,
  input  logic                       finish,
  output logic [COARSE_W+FINE_W-1:0] ts_data,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic [CNT_W-1:0]           glitch_cnt
);

  localparam int unsigned NGRP          = NTAPS / 8;
  localparam int unsigned TS_W          = COARSE_W + FINE_W;
  localparam int unsigned TS_COARSE_LSB = TS_FINE_LSB + FINE_W;

  tdc_state_e          state_q;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [NTAPS-1:0]    cap_taps_q;
  logic [COARSE_W-1:0] cap_coarse_q;
  logic                launch;

  logic [3:0]          grp_cnt_d [NGRP];
  logic [3:0]          e1_grp_q  [NGRP];
  logic [COARSE_W-1:0] e1_coarse_q;
  logic                e1_valid_q;

  logic [FINE_W-1:0]   fine_d;
  logic [FINE_W-1:0]   e2_fine_q;
  logic [COARSE_W-1:0] e2_coarse_q;
  logic                e2_valid_q;

  logic [CNT_W-1:0]    ovf_q, glitch_q;
  logic [TS_W-1:0]     fifo_wdata;
  logic                fifo_empty, fifo_full, fifo_pop;
  logic [FIFO_AW:0]    fifo_level_unused;

  // Free-running coarse time; wraps silently.
  assign coarse_d = coarse_q + COARSE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) coarse_q <= '0;
    else     coarse_q <= coarse_d;
  end

  // A pending capture confirmed by finish moves into the encode pipeline.
  assign launch = (state_q == WAIT_FIN) && finish;

  // Capture FSM. A valid always (re)captures; an unconfirmed capture or a finish
  // with nothing pending counts as a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      glitch_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (finish) glitch_q <= sat_inc(glitch_q);
          if (valid)  state_q  <= WAIT_FIN;
        end
        WAIT_FIN: begin
          if (!finish) glitch_q <= sat_inc(glitch_q);
          state_q <= valid ? WAIT_FIN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture data: the coarse value is the one present in the valid cycle.
  always_ff @(posedge clk) begin
    if (valid) begin
      cap_taps_q   <= taps ^ {NTAPS{TAP_INV}};
      cap_coarse_q <= coarse_q;
    end
  end

  // E1: per-byte popcount. Counting ones instead of locating the edge makes
  // the fine value tolerant of bubbles in the thermometer code.
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_cnt_d[g] = '0;
      for (int b = 0; b < 8; b++) begin
        grp_cnt_d[g] = grp_cnt_d[g] + {3'b000, cap_taps_q[g*8 + b]};
      end
    end
  end

  // E2: sum of group counts, 0..NTAPS.
  always_comb begin
    fine_d = '0;
    for (int g = 0; g < NGRP; g++) begin
      fine_d = fine_d + FINE_W'(e1_grp_q[g]);
    end
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      e1_grp_q    <= grp_cnt_d;
      e1_coarse_q <= cap_coarse_q;
    end
    if (e1_valid_q) begin
      e2_fine_q   <= fine_d;
      e2_coarse_q <= e1_coarse_q;
    end
  end

  // Only the stage valids need reset; a reset mid-event flushes the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid_q <= 1'b0;
      e2_valid_q <= 1'b0;
    end else begin
      e1_valid_q <= launch;
      e2_valid_q <= e1_valid_q;
    end
  end

  always_comb begin
    fifo_wdata = '0;
    fifo_wdata[TS_FINE_LSB   +: FINE_W]   = e2_fine_q;
    fifo_wdata[TS_COARSE_LSB +: COARSE_W] = e2_coarse_q;
  end

  assign fifo_pop = ts_ready & ~fifo_empty;

  // The pipeline never stalls: a write into a full FIFO with no simultaneous
  // read is dropped and counted.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else if (e2_valid_q && fifo_full && !fifo_pop) ovf_q <= sat_inc(ovf_q);
  end

  // Occupancy is exported by the FIFO for later readout stages; not needed here.
  tdc_ts_fifo #(
    .DW (TS_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (e2_valid_q),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (ts_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_level_unused)
  );

  assign ts_valid   = ~fifo_empty;
  assign ovf_cnt    = ovf_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// tb_tdc_hit_encoder: directed self-checking bench for tdc_hit_encoder with
// default parameters (NTAPS=64, COARSE_W=16, FINE_W=7, FIFO_AW=2, TAP_INV=0).
module tb_tdc_hit_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] taps = '0;
  logic        valid = 1'b0;
  logic        finish = 1'b0;
  logic        ts_ready = 1'b0;
  logic [22:0] ts_data;
  logic        ts_valid;
  logic [7:0]  ovf_cnt;
  logic [7:0]  glitch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference coarse counter kept by the bench.
  logic [15:0] mc;

  tdc_hit_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .taps       (taps),
    .valid      (valid),
    .finish     (finish),
    .ts_data    (ts_data),
    .ts_valid   (ts_valid),
    .ts_ready   (ts_ready),
    .ovf_cnt    (ovf_cnt),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mc <= rst ? 16'd0 : mc + 16'd1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] ts(input logic [15:0] c, input int f);
    logic [6:0] fine;
    fine = 7'(f);
    return {c, fine};
  endfunction

  task automatic wait_coarse(input logic [15:0] v);
    while (mc != v) tick;
  endtask

  // valid in cycle t, finish (if fin) in t+1; returns in t+2 with c = coarse at t.
  task automatic send_event(input logic [63:0] tv, input bit fin, output logic [15:0] c);
    c      = mc;
    valid  = 1'b1;
    taps   = tv;
    tick;
    valid  = 1'b0;
    finish = fin;
    tick;
    finish = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [22:0] exp);
    for (int i = 0; i < 16 && !ts_valid; i++) tick;
    check({tag, "_valid"}, 64'(ts_valid), 64'd1);
    check(tag, 64'(ts_data), 64'(exp));
    ts_ready = 1'b1;
    tick;
    ts_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] c, c2;
    logic [15:0] cq [6];

    // Reset state
    repeat (3) tick;
    check("rst_ts_valid", 64'(ts_valid), 64'd0);
    check("rst_ts_data", 64'(ts_data), 64'd0);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    check("rst_glitch", 64'(glitch_cnt), 64'd0);
    rst = 1'b0;

    // Basic event at coarse 0x0123, 16 taps set; ts_valid appears in t+4
    wait_coarse(16'h0123);
    send_event(64'h0000_0000_0000_FFFF, 1'b1, c);
    tick;
    check("basic_t3_valid", 64'(ts_valid), 64'd0);
    tick;
    check("basic_t4_valid", 64'(ts_valid), 64'd1);
    check("basic_data", 64'(ts_data), 64'(ts(16'h0123, 16)));
    ts_ready = 1'b1;
    tick;
    ts_ready = 1'b0;
    check("basic_empty", 64'(ts_valid), 64'd0);
    check("basic_hold", 64'(ts_data), 64'(ts(16'h0123, 16)));

    // Bubble and bounds
    send_event(64'h0000_0000_0000_FFF7, 1'b1, c);
    pop_expect("bubble", ts(c, 15));
    send_event('1, 1'b1, c);
    pop_expect("all_ones", ts(c, 64));
    send_event('0, 1'b1, c);
    pop_expect("all_zeros", ts(c, 0));

    // Protocol errors
    send_event(64'hFF, 1'b0, c);
    repeat (5) tick;
    check("nofin_no_write", 64'(ts_valid), 64'd0);
    check("nofin_glitch", 64'(glitch_cnt), 64'd1);

    finish = 1'b1;
    tick;
    finish = 1'b0;
    tick;
    check("lone_fin_glitch", 64'(glitch_cnt), 64'd2);

    valid = 1'b1;
    taps  = '1;
    tick;
    c2   = mc;
    taps = 64'hFF;
    tick;
    valid  = 1'b0;
    finish = 1'b1;
    tick;
    finish = 1'b0;
    pop_expect("double_valid", ts(c2, 8));
    check("double_valid_glitch", 64'(glitch_cnt), 64'd3);
    check("double_valid_empty", 64'(ts_valid), 64'd0);

    // Backpressure: 6 events into a 4-deep FIFO
    for (int i = 0; i < 6; i++) send_event((64'd1 << (i + 1)) - 64'd1, 1'b1, cq[i]);
    repeat (4) tick;
    check("bp_ovf", 64'(ovf_cnt), 64'd2);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("bp_pop%0d", i), ts(cq[i], i + 1));
    tick;
    check("bp_drained", 64'(ts_valid), 64'd0);

    // Full FIFO with a read in the write cycle
    for (int i = 0; i < 4; i++) send_event((64'd1 << (10 + i)) - 64'd1, 1'b1, cq[i]);
    repeat (4) tick;
    check("fr_full_valid", 64'(ts_valid), 64'd1);
    check("fr_ovf_before", 64'(ovf_cnt), 64'd2);
    send_event((64'd1 << 20) - 64'd1, 1'b1, cq[4]);
    tick;
    check("fr_head", 64'(ts_data), 64'(ts(cq[0], 10)));
    ts_ready = 1'b1;
    tick;
    ts_ready = 1'b0;
    tick;
    check("fr_ovf_after", 64'(ovf_cnt), 64'd2);
    for (int i = 1; i < 4; i++) pop_expect($sformatf("fr_pop%0d", i), ts(cq[i], 10 + i));
    pop_expect("fr_pop_new", ts(cq[4], 20));
    tick;
    check("fr_drained", 64'(ts_valid), 64'd0);

    // Coarse wrap: event at 0xFFFF, next one two cycles later at 0x0001
    wait_coarse(16'hFFFF);
    send_event(64'hFFFF_FFFF, 1'b1, c);
    send_event(64'h7, 1'b1, c2);
    pop_expect("wrap_ffff", ts(16'hFFFF, 32));
    pop_expect("wrap_0001", ts(16'h0001, 3));

    // Reset one cycle after finish flushes the event and clears counters
    send_event(64'hF, 1'b1, c);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_glitch", 64'(glitch_cnt), 64'd0);
    check("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
    check("mid_rst_valid", 64'(ts_valid), 64'd0);
    check("mid_rst_data", 64'(ts_data), 64'd0);
    // First cycle after reset has coarse 0; any leaked old event would appear first.
    send_event(64'h3F, 1'b1, c);
    pop_expect("post_rst", ts(16'h0000, 6));
    repeat (6) tick;
    check("post_rst_empty", 64'(ts_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
